// File: rtl/riscv_axi_lite_regfile.sv
// AXI4-Lite slave register file.
// Writable control registers are exported on reg_out; read-only registers
// return the matching status_in slice. Writes answer SLVERR for read-only or
// unmapped registers, and reads answer SLVERR for unmapped registers.
// The AW and W channels are latched independently and committed together.
module riscv_axi_lite_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_strobe
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  ready_en;
  logic                  aw_full;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  wr_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_word;

  // Protection bits, sub-word address bits and status slices of writable
  // registers carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0],
                           status_in};

  // ready_en keeps all READYs low in reset and for the release cycle
  assign S_AXI_AWREADY = ready_en & ~aw_full & ~bvalid_q;
  assign S_AXI_WREADY  = ready_en & ~w_full & ~bvalid_q;
  assign S_AXI_ARREADY = ready_en & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full & w_full;
  assign rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  // Decode the latched write index and the live read index
  always_comb begin
    wr_sel  = '0;
    rd_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) begin
        wr_sel[i] = ~RO_MASK[i];
      end
      if (rd_idx == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_word = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  assign wr_ok = |wr_sel;

  // Export writable registers; read-only slices are tied to zero
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end
  end

  // Open the READYs one edge after reset release
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // AW/W latching, commit and write response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full   <= 1'b0;
      aw_idx    <= '0;
      w_full    <= 1'b0;
      w_data    <= '0;
      w_strb    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_strobe <= '0;
    end else begin
      wr_strobe <= '0;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full   <= 1'b0;
        w_full    <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        wr_strobe <= wr_sel;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Byte-lane merge into the selected register on commit
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) begin
              regs[i][8*b +: 8] <= w_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read channel: data captured at the AR handshake, held until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_hit ? rd_word : '0;
        rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule
